tick_counter_seg: RTL and testbench
===================================

Name: tick_counter_seg

Overview:
- Synchronous counter stage sitting directly downstream of the clock-divider/input-conditioning stage.
- Consumes the divided timebase as a single-clock enable tick, never as a ripple clock. Also consumes the 4-bit conditioned input nibble.
- Provides a modulo up/down counter with synchronised load and hold controls.
- Drives a registered 7-segment decode of the count plus a divided-clock indicator, for the board display pins.

Parameters:
- DIV, 4, prescaler ratio: one count tick every DIV enabled clocks; legal range 2..256.
- MOD, 10, counter modulus: count runs 0..MOD-1; legal range 2..16.

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset; deasserted synchronously by the top level.
- ena  input  1  design enable; 0 freezes the prescaler, so no ticks are generated.
- din  input  4  load value (conditioned nibble); sampled only on a load event.
- load_in  input  1  asynchronous load request; a rising edge loads din.
- hold_in  input  1  asynchronous hold level; 1 freezes the count.
- dir_in  input  1  asynchronous direction; 1 = up, 0 = down.
- count  output  4  current count value.
- seg  output  7  segments a..g on bits 0..6, active high.
- dp  output  1  divided-clock indicator; toggles on every tick.
- wrap  output  1  one-clock pulse when the count wraps.

Behaviour:
- Reset (rst_n=0, asynchronous): all flops cleared. Outputs during and after reset:
  - count=0
  - seg=7'h3F (digit 0)
  - dp=0, wrap=0
  - prescaler=0
  - synchroniser and edge-detect flops=0
- Synchronisers: load_in, hold_in and dir_in each pass through a 2-flop synchroniser. A load event is detected on the synchronised load_in 0->1 transition, i.e. 3 clk after the pin edge. din is sampled in the same cycle as the load event; it is static by protocol and is not synchronised.
- Prescaler:
  - Counts 0..DIV-1 while ena=1 and holds its value while ena=0.
  - tick=1 for exactly the one cycle in which prescaler==DIV-1 and ena=1; the prescaler wraps to 0 on that cycle.
  - Load and hold do not affect the prescaler.
- Counter update, priority highest first:
  - 1. Load event: count <= min(din, MOD-1); wrap=0. The load takes effect even when ena=0 or hold=1.
  - 2. Synchronised hold=1: count unchanged; wrap=0. A tick during hold is lost, not deferred.
  - 3. Tick with dir=1: if count==MOD-1 then count <= 0 and wrap pulses; else count+1.
  - 4. Tick with dir=0: if count==0 then count <= MOD-1 and wrap pulses; else count-1.
  - 5. Otherwise no change.
- wrap: registered; high for exactly the one clk in which the wrapped count value first appears.
- dp: toggles on every tick regardless of hold/load. This gives a period of 2*DIV enabled clocks at 50% duty; it is the synchronous equivalent of the divided clock.
- seg: registered hex decode of count, so it lags count by one clk. Encodings:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
- Direction change takes effect on the first tick after the synchronised value changes; no glitch, no extra step.
- Reset mid-operation: immediate return to the reset values above. Counting resumes from 0 with the prescaler at 0, so the first tick comes DIV enabled clocks after release.
- Latency summary:
  - tick -> count: 1 clk
  - count -> seg: 1 clk
  - load_in pin edge -> count: 3 clk
  - load_in pin edge -> seg: 4 clk

Test Plan:
- Reset/idle: assert rst_n=0 mid-count, release with ena=1, dir=1, defaults -> count=0 and seg=3F at release. First increment to 1 occurs 4 clk later, seg=06 one clk after that. dp toggles every 4 clk.
- Up wrap: count from 0 with dir=1 for 10 ticks -> sequence 0..9,0. wrap is high exactly 1 clk, coincident with count 9->0. seg shows 6F then 3F.
- Down wrap: load din=0, dir=0, one tick -> count=9 and wrap pulses. Further ticks give 8, 7, ... with no wrap.
- Load/clamp/priority:
  - load din=4'hC with MOD=10 -> count=9.
  - load din=3 in the same cycle as a tick and with hold=1 -> count=3, no step, wrap=0.
  - Load edge to count change measures 3 clk.
- Hold and ena:
  - hold=1 for 3 ticks -> count frozen, dp still toggles 3 times.
  - ena=0 for 20 clk -> no ticks, dp and prescaler frozen. The next tick comes exactly DIV-p enabled clks after ena returns (p = frozen prescaler value).
- Parameter sweep: DIV=2, MOD=16 -> count runs 0..F with tick every 2 clk. seg decodes A..F as 77, 7C, 39, 5E, 79, 71, then wraps to 0 with a wrap pulse.

Source files
------------

// File: rtl/tick_counter_seg_if.sv
// Purpose : pin bundle between the board-side driver and tick_counter_seg.
// Ports   : ena/din/load_in/hold_in/dir_in run driver -> counter;
//           count/seg/dp/wrap run counter -> display pins.
interface tick_counter_seg_if;
  logic       ena;
  logic [3:0] din;
  logic       load_in;
  logic       hold_in;
  logic       dir_in;
  logic [3:0] count;
  logic [6:0] seg;
  logic       dp;
  logic       wrap;

  modport master (
    output ena, din, load_in, hold_in, dir_in,
    input  count, seg, dp, wrap
  );

  modport slave (
    input  ena, din, load_in, hold_in, dir_in,
    output count, seg, dp, wrap
  );
endinterface

// File: rtl/tick_counter_seg.sv
// Purpose : modulo up/down counter advanced by a prescaled enable tick, with
//           synchronised load/hold/dir controls and a registered 7-seg decode.
// Ports   : clk, rst_n (async active-low); bus.slave carries ena, din,
//           load_in, hold_in, dir_in in and count, seg, dp, wrap out.
// Latency : tick->count 1 clk, count->seg 1 clk, load_in pin->count 3 clk.
module tick_counter_seg #(
  parameter int DIV = 4,   // one tick every DIV enabled clocks, 2..256
  parameter int MOD = 10   // count runs 0..MOD-1, 2..16
) (
  input  logic              clk,
  input  logic              rst_n,
  tick_counter_seg_if.slave bus
);

  localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);
  localparam logic [3:0]      CNT_MAX = 4'(MOD - 1);

  // Two-flop synchronisers; load has a third flop for rising-edge detect.
  logic load_s1_q, load_s2_q, load_s3_q;
  logic hold_s1_q, hold_s2_q;
  logic dir_s1_q,  dir_s2_q;

  logic [PW-1:0] pre_q,   pre_d;
  logic [3:0]    count_q, count_d;
  logic          wrap_q,  wrap_d;
  logic          dp_q,    dp_d;
  logic [6:0]    seg_q;

  logic tick;
  logic load_evt;

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick     = bus.ena && (pre_q == PRE_MAX);
  assign load_evt = load_s2_q && !load_s3_q;

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    dp_d    = dp_q ^ tick;   // dp follows the raw tick, independent of load/hold

    if (bus.ena) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    if (load_evt) begin
      count_d = (bus.din > CNT_MAX) ? CNT_MAX : bus.din;
    end else if (hold_s2_q) begin
      count_d = count_q;     // a tick arriving here is dropped, not queued
    end else if (tick) begin
      if (dir_s2_q) begin
        if (count_q == CNT_MAX) begin
          count_d = 4'h0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 4'h1;
        end
      end else begin
        if (count_q == 4'h0) begin
          count_d = CNT_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 4'h1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
      load_s3_q <= 1'b0;
      hold_s1_q <= 1'b0;
      hold_s2_q <= 1'b0;
      dir_s1_q  <= 1'b0;
      dir_s2_q  <= 1'b0;
      pre_q     <= '0;
      count_q   <= 4'h0;
      wrap_q    <= 1'b0;
      dp_q      <= 1'b0;
      seg_q     <= 7'h3F;
    end else begin
      load_s1_q <= bus.load_in;
      load_s2_q <= load_s1_q;
      load_s3_q <= load_s2_q;
      hold_s1_q <= bus.hold_in;
      hold_s2_q <= hold_s1_q;
      dir_s1_q  <= bus.dir_in;
      dir_s2_q  <= dir_s1_q;
      pre_q     <= pre_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      dp_q      <= dp_d;
      seg_q     <= seg_dec(count_q);
    end
  end

  assign bus.count = count_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_tick_counter_seg.sv
// Directed bench: instance A (DIV=4, MOD=10) and instance B (DIV=2, MOD=16).
// All stimulus changes and output samples happen on the falling clock edge;
// positions in comments are rising edges counted from the last reset release.
module tb_tick_counter_seg;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [6:0] seg_tab [16];

  tick_counter_seg_if ifa ();
  tick_counter_seg_if ifb ();

  tick_counter_seg #(.DIV(4), .MOD(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  tick_counter_seg #(.DIV(2), .MOD(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

    rst_n = 1'b0;
    ifa.ena = 1'b1; ifa.din = 4'h0; ifa.load_in = 1'b0; ifa.hold_in = 1'b0; ifa.dir_in = 1'b1;
    ifb.ena = 1'b1; ifb.din = 4'h0; ifb.load_in = 1'b0; ifb.hold_in = 1'b0; ifb.dir_in = 1'b1;

    step(3);
    rst_n = 1'b1;
    step(10);                                   // ticks at 4 and 8
    chk("a_precount", ifa.count, 4'd2);

    // reset asserted mid-count clears outputs immediately
    rst_n = 1'b0;
    #1;
    chk("a_rst_count", ifa.count, 4'd0);
    chk("a_rst_seg",   ifa.seg,   7'h3F);
    chk("a_rst_dp",    ifa.dp,    1'b0);
    step(2);
    rst_n = 1'b1;                               // position 0
    chk("a_rel_count", ifa.count, 4'd0);
    chk("a_rel_seg",   ifa.seg,   7'h3F);
    chk("a_rel_wrap",  ifa.wrap,  1'b0);

    // up count: ticks at 4k, seg trails count by one clock
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("a_up_seg", ifa.seg, seg_tab[(k - 1) % 10]);
      step(3);
      chk("a_up_count", ifa.count, k % 10);
      chk("a_up_wrap",  ifa.wrap,  (k == 10));
      chk("a_up_dp",    ifa.dp,    k & 1);
    end
    step(1);                                    // 41
    chk("a_wrap_seg",   ifa.seg,  7'h3F);
    chk("a_wrap_1clk",  ifa.wrap, 1'b0);

    // down wrap: load 0 (lands on tick edge 44, load wins), then tick at 48
    ifa.din = 4'h0; ifa.dir_in = 1'b0; ifa.load_in = 1'b1;
    step(3);                                    // 44
    chk("a_ld0_count", ifa.count, 4'd0);
    chk("a_ld0_wrap",  ifa.wrap,  1'b0);
    ifa.load_in = 1'b0;
    step(4);                                    // 48
    chk("a_dn_count", ifa.count, 4'd9);
    chk("a_dn_wrap",  ifa.wrap,  1'b1);
    step(1);                                    // 49
    chk("a_dn_wrap_end", ifa.wrap, 1'b0);
    step(3);                                    // 52
    chk("a_dn8", ifa.count, 4'd8);
    chk("a_dn8_wrap", ifa.wrap, 1'b0);
    step(4);                                    // 56
    chk("a_dn7", ifa.count, 4'd7);

    // clamp: din=C loads as 9, exactly 3 clocks after the pin edge
    ifa.din = 4'hC; ifa.load_in = 1'b1;
    step(2);                                    // 58
    chk("a_ld_lat2", ifa.count, 4'd7);
    step(1);                                    // 59
    chk("a_clamp", ifa.count, 4'd9);
    ifa.load_in = 1'b0;
    step(1);                                    // 60: tick, down to 8
    chk("a_clamp_seg", ifa.seg,   7'h6F);
    chk("a_after_ld",  ifa.count, 4'd8);

    // load din=3 on tick edge 64 with hold active
    ifa.hold_in = 1'b1; ifa.din = 4'h3;
    step(1);                                    // 61
    ifa.load_in = 1'b1;
    step(1);                                    // 62
    ifa.load_in = 1'b0;
    step(1);                                    // 63
    chk("a_hold_pre", ifa.count, 4'd8);
    step(1);                                    // 64
    chk("a_ldhold_count", ifa.count, 4'd3);
    chk("a_ldhold_wrap",  ifa.wrap,  1'b0);
    chk("a_ldhold_dp",    ifa.dp,    1'b0);

    // hold over three ticks: count frozen, dp keeps toggling
    for (int j = 1; j <= 3; j++) begin
      step(4);                                  // 68, 72, 76
      chk("a_hold_count", ifa.count, 4'd3);
      chk("a_hold_dp",    ifa.dp,    j & 1);
      chk("a_hold_wrap",  ifa.wrap,  1'b0);
    end
    ifa.hold_in = 1'b0;
    step(4);                                    // 80
    chk("a_unhold", ifa.count, 4'd2);

    // ena low for 20 clocks with prescaler frozen at 1
    step(1);                                    // 81
    ifa.ena = 1'b0;
    step(20);                                   // 101
    chk("a_ena_count", ifa.count, 4'd2);
    chk("a_ena_dp",    ifa.dp,    1'b0);
    ifa.ena = 1'b1;
    step(2);                                    // 103
    chk("a_ena_early", ifa.count, 4'd2);
    step(1);                                    // 104: DIV-1 = 3 enabled clocks
    chk("a_ena_tick",  ifa.count, 4'd1);
    chk("a_ena_tdp",   ifa.dp,    1'b1);

    // instance B: DIV=2, MOD=16 full hex sweep
    rst_n = 1'b0;
    ifb.ena = 1'b0;
    #1;
    chk("a_rst2_count", ifa.count, 4'd0);
    chk("a_rst2_seg",   ifa.seg,   7'h3F);
    step(2);
    rst_n = 1'b1;
    step(3);                                    // dir synchroniser settled
    chk("b_rst_count", ifb.count, 4'd0);
    chk("b_rst_seg",   ifb.seg,   7'h3F);
    ifb.ena = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("b_seg", ifb.seg, seg_tab[k - 1]);
      step(1);
      chk("b_count", ifb.count, k % 16);
      chk("b_wrap",  ifb.wrap,  (k == 16));
    end
    step(1);
    chk("b_wrap_seg", ifb.seg,  7'h3F);
    chk("b_wrap_end", ifb.wrap, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
